tff_count_ctrl: RTL and testbench

Sequencer for a WIDTH-bit bank of toggle flip-flops used as a programmable modulo counter. Generates the per-bit toggle enables each cycle, holds the resulting count, and wraps it in a start/stop/pause handshake with one-shot and periodic modes. Sits between a requesting controller and any T-FF counter datapath: the `toggle` vector drives the T inputs, and `count` mirrors the bank state.

---
 rtl/tff_count_ctrl.sv | 110 +++++++++++
 tb/tb_tff_count_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/tff_count_ctrl.sv
// Start/stop/pause sequencer for a bank of T flip-flops forming a modulo counter.
// Produces per-bit toggle enables and mirrors the resulting count.
module tff_count_ctrl #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic [WIDTH-1:0] toggle,
    output logic             busy,
    output logic             tc,
    output logic             done
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_PAUSE,
        S_DONE
    } state_t;

    state_t           state;
    state_t           nxt_state;
    logic [WIDTH-1:0] lim;
    logic             md;
    logic [WIDTH-1:0] nxt_count;
    logic             at_lim;
    logic             tc_raw;
    logic             load;
    logic             busy_r;
    logic             done_r;

    assign at_lim = (count == lim);

    always_comb begin
        nxt_state = state;
        nxt_count = count;
        tc_raw    = 1'b0;
        load      = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    nxt_state = S_RUN;
                    nxt_count = '0;
                end
            end
            S_RUN: begin
                // stop pre-empts both increment and terminal handling
                if (stop) begin
                    nxt_state = S_PAUSE;
                end else if (at_lim) begin
                    tc_raw = 1'b1;
                    if (md) begin
                        nxt_count = '0;
                    end else begin
                        nxt_state = S_DONE;
                    end
                end else begin
                    nxt_count = count + WIDTH'(1);
                end
            end
            S_PAUSE: begin
                if (stop) begin
                    nxt_state = S_IDLE;
                    nxt_count = '0;
                end else if (start) begin
                    nxt_state = S_RUN;
                end
            end
            S_DONE: begin
                nxt_state = S_IDLE;
            end
            default: begin
                nxt_state = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= S_IDLE;
            count  <= '0;
            lim    <= '0;
            md     <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            state  <= nxt_state;
            count  <= nxt_count;
            busy_r <= (nxt_state == S_RUN) || (nxt_state == S_PAUSE);
            done_r <= (nxt_state == S_DONE);
            if (load) begin
                lim <= limit;
                md  <= mode;
            end
        end
    end

    // Outputs are forced quiet for the whole time reset is held.
    assign toggle = reset ? '0 : (count ^ nxt_count);
    assign tc     = tc_raw & ~reset;
    assign busy   = busy_r & ~reset;
    assign done   = done_r & ~reset;

endmodule

// File: tb/tb_tff_count_ctrl.sv
// Bench for tff_count_ctrl: directed scenarios plus random start/stop traffic
// compared every cycle against a behavioural model of the sequencer.
module tb_tff_count_ctrl;

    localparam int S_IDLE  = 0;
    localparam int S_RUN   = 1;
    localparam int S_PAUSE = 2;
    localparam int S_DONE  = 3;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       stop;
    logic       mode;
    logic [3:0] limit;
    logic [3:0] count;
    logic [3:0] toggle;
    logic       busy;
    logic       tc;
    logic       done;

    int total = 0;
    int bad   = 0;
    int tc_seen = 0;
    int done_seen = 0;

    int         st = S_IDLE;
    logic [3:0] mcnt = '0;
    logic [3:0] mlim = '0;
    bit         mmd = 1'b0;
    bit         valid = 1'b0;
    logic [3:0] pcnt = '0;
    logic [3:0] ptog = '0;
    bit         pvalid = 1'b0;

    tff_count_ctrl #(.WIDTH(4)) dut (
        .clk   (clk),
        .reset (reset),
        .start (start),
        .stop  (stop),
        .mode  (mode),
        .limit (limit),
        .count (count),
        .toggle(toggle),
        .busy  (busy),
        .tc    (tc),
        .done  (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input bit r, input bit s, input bit p,
                        input bit md, input logic [3:0] l);
        int         nst;
        logic [3:0] ncnt;
        logic [3:0] nlim;
        bit         nmd;
        bit         etc;
        @(negedge clk);
        reset = r;
        start = s;
        stop  = p;
        mode  = md;
        limit = l;
        #1;
        nst  = st;
        ncnt = mcnt;
        nlim = mlim;
        nmd  = mmd;
        etc  = 1'b0;
        if (r) begin
            nst  = S_IDLE;
            ncnt = '0;
            nlim = '0;
            nmd  = 1'b0;
        end else begin
            case (st)
                S_IDLE: if (s) begin
                    nst = S_RUN; ncnt = '0; nlim = l; nmd = md;
                end
                S_RUN: begin
                    if (p) nst = S_PAUSE;
                    else if (mcnt == mlim) begin
                        etc = 1'b1;
                        if (mmd) ncnt = '0;
                        else nst = S_DONE;
                    end else ncnt = 4'((int'(mcnt) + 1) % 16);
                end
                S_PAUSE: begin
                    if (p) begin nst = S_IDLE; ncnt = '0; end
                    else if (s) nst = S_RUN;
                end
                default: nst = S_IDLE;
            endcase
        end
        if (pvalid) chk("xor_inv", int'(count), int'(pcnt ^ ptog));
        if (valid) chk("count", int'(count), int'(mcnt));
        chk("tc", int'(tc), int'(etc));
        chk("busy", int'(busy), int'(!r && (st == S_RUN || st == S_PAUSE)));
        chk("done", int'(done), int'(!r && st == S_DONE));
        if (valid || r) chk("toggle", int'(toggle), r ? 0 : int'(mcnt ^ ncnt));
        if (tc === 1'b1) tc_seen++;
        if (done === 1'b1) done_seen++;
        pcnt   = count;
        ptog   = toggle;
        pvalid = !r;
        @(posedge clk);
        st    = nst;
        mcnt  = ncnt;
        mlim  = nlim;
        mmd   = nmd;
        valid = valid | r;
    endtask

    task automatic idle(input int n, input logic [3:0] l);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, l);
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0; limit = '0;
        step(1, 1, 1, 1, 4'd9);
        step(1, 0, 0, 0, 0);
        chk("reset_count", int'(count), 0);

        // one-shot to 5
        done_seen = 0;
        step(0, 1, 0, 0, 4'd5);
        idle(9, 4'd5);
        chk("oneshot_hold", int'(count), 5);
        chk("oneshot_done_n", done_seen, 1);

        // periodic full range, 40 cycles
        tc_seen = 0;
        step(0, 1, 0, 1, 4'd15);
        idle(40, 4'd3);
        chk("periodic_tc_n", tc_seen, 2);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);

        // limit zero, periodic then one-shot
        tc_seen = 0;
        step(0, 1, 0, 1, 4'd0);
        idle(6, 4'd7);
        chk("lim0_tc_n", tc_seen, 6);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        done_seen = 0;
        step(0, 1, 0, 0, 4'd0);
        idle(4, 4'd0);
        chk("lim0_done_n", done_seen, 1);

        // pause, resume, abort
        done_seen = 0;
        step(0, 1, 0, 0, 4'd10);
        idle(3, 4'd10);
        step(0, 0, 1, 0, 0);
        idle(4, 0);
        chk("pause_frozen", int'(count), 3);
        step(0, 1, 0, 0, 0);
        idle(3, 0);
        step(0, 0, 1, 0, 0);
        step(0, 0, 1, 0, 0);
        idle(2, 0);
        chk("abort_count", int'(count), 0);
        chk("abort_no_done", done_seen, 0);

        // ignored inputs and start+stop priority
        step(0, 1, 0, 0, 4'd8);
        idle(2, 4'd1);
        step(0, 1, 0, 1, 4'd1);
        idle(2, 4'd2);
        step(0, 0, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        idle(2, 0);
        step(0, 1, 0, 0, 4'd2);
        for (int i = 0; i < 6; i++) step(0, 1, 0, 1, 4'd4);
        idle(12, 0);

        // reset mid-run
        step(0, 1, 0, 0, 4'd10);
        idle(6, 4'd10);
        step(1, 0, 0, 0, 0);
        idle(3, 0);
        chk("midrst_count", int'(count), 0);

        // random traffic
        for (int i = 0; i < 1500; i++) begin
            step($urandom_range(0, 99) == 0,
                 $urandom_range(0, 9) == 0,
                 $urandom_range(0, 14) == 0,
                 1'($urandom_range(0, 1)),
                 4'($urandom_range(0, 15)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
